// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and counter-width helper for the piso_tx transmitter.
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_t;
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/piso_if.sv
// piso_if: parallel word input and serial output stream of piso_tx.
// in_data/in_valid/in_ready: word handshake; ser_out/ser_valid/ser_last/ser_ready: bit stream; busy: word in flight.
// master drives the word and ser_ready; slave is the transmitter.
interface piso_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic ser_out;
  logic ser_valid;
  logic ser_last;
  logic ser_ready;
  logic busy;
  modport master (
    output in_data, in_valid, ser_ready,
    input in_ready, ser_out, ser_valid, ser_last, busy
  );
  modport slave (
    input in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_shreg.sv
// piso_shreg: WIDTH-bit shift register with load, zero-filling shift toward the output end.
// clk/rst: clock, sync active-high reset; load_i/data_i: parallel load (wins over shift);
// shift_i: advance one bit; bit_o: bit at the output end.
module piso_shreg #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);
  logic [WIDTH-1:0] shreg_q;
  always_ff @(posedge clk) begin
    if (rst) shreg_q <= '0;
    else if (load_i) shreg_q <= data_i;
    else if (shift_i) shreg_q <= MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
  end
  assign bit_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, one word in, one bit per accepted beat out.
// clk/rst: clock, sync active-high reset; bus: piso_if slave (word handshake in, bit stream out, busy).
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic   clk,
  input logic   rst,
  piso_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  piso_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last, take_bit, rdy, accept;
  always_comb begin
    last = state_q == SHIFT && cnt_q == LAST;
    take_bit = state_q == SHIFT && bus.ser_ready;
    // the final beat reopens the input so the next word follows with no bubble
    rdy = !rst && (state_q == IDLE || (last && bus.ser_ready));
    accept = rdy && bus.in_valid;
    state_d = accept ? SHIFT : (take_bit && last) ? IDLE : state_q;
    cnt_d = (accept || (take_bit && last)) ? '0 : take_bit ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  piso_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
    .clk(clk),
    .rst(rst),
    .load_i(accept),
    .shift_i(take_bit),
    .data_i(bus.in_data),
    .bit_o(bus.ser_out)
  );
  assign bus.in_ready = rdy;
  assign bus.ser_valid = state_q == SHIFT;
  assign bus.busy = state_q == SHIFT;
  assign bus.ser_last = last;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed vector bench for piso_tx (8-bit LSB-first, 8-bit MSB-first, 1-bit).
module tb_piso_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  piso_if #(.WIDTH(8)) a ();
  piso_if #(.WIDTH(8)) b ();
  piso_if #(.WIDTH(1)) c ();
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(a.slave));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(b.slave));
  piso_tx #(.WIDTH(1), .MSB_FIRST(1'b0)) u_w1 (.clk(clk), .rst(rst), .bus(c.slave));
  // e packs {in_ready, ser_valid, ser_out, ser_last, busy}
  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       sr;
    logic [4:0] e;
  } vec_t;
  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] w;
  logic [3:0] ws;
  logic sr;
  function automatic vec_t v(input logic iv, input logic [7:0] d, input logic sr_, input logic [4:0] e);
    vec_t r;
    r.iv = iv;
    r.d = d;
    r.sr = sr_;
    r.e = e;
    return r;
  endfunction
  function automatic logic [4:0] sa();
    return {a.in_ready, a.ser_valid, a.ser_out, a.ser_last, a.busy};
  endfunction
  function automatic logic [4:0] sb();
    return {b.in_ready, b.ser_valid, b.ser_out, b.ser_last, b.busy};
  endfunction
  function automatic logic [4:0] sc();
    return {c.in_ready, c.ser_valid, c.ser_out, c.ser_last, c.busy};
  endfunction
  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (rdy,val,out,last,busy)", nm, act, exp);
    end
  endtask
  initial begin
    a.in_valid = 0; a.in_data = '0; a.ser_ready = 1;
    b.in_valid = 0; b.in_data = '0; b.ser_ready = 1;
    c.in_valid = 0; c.in_data = '0; c.ser_ready = 1;
    // LSB-first 0x01, free flowing
    tbl.push_back(v(1, 8'h01, 1, 5'b10000));
    tbl.push_back(v(0, 8'h00, 1, 5'b01101));
    repeat (6) tbl.push_back(v(0, 8'h00, 1, 5'b01001));
    tbl.push_back(v(0, 8'h00, 1, 5'b11011));
    tbl.push_back(v(0, 8'h00, 1, 5'b10000));
    // back-to-back 0xF0 then 0x0F; in_data churns while shifting
    tbl.push_back(v(1, 8'hF0, 1, 5'b10000));
    repeat (4) tbl.push_back(v(1, 8'h3C, 1, 5'b01001));
    repeat (3) tbl.push_back(v(1, 8'h3C, 1, 5'b01101));
    tbl.push_back(v(1, 8'h0F, 1, 5'b11111));
    repeat (4) tbl.push_back(v(0, 8'h00, 1, 5'b01101));
    repeat (3) tbl.push_back(v(0, 8'h00, 1, 5'b01001));
    tbl.push_back(v(0, 8'h00, 1, 5'b11011));
    tbl.push_back(v(0, 8'h00, 1, 5'b10000));
    @(negedge clk);
    #1;
    chk("reset_lsb", sa(), 5'b00000);
    chk("reset_msb", sb(), 5'b00000);
    chk("reset_w1", sc(), 5'b00000);
    rst = 0;
    foreach (tbl[i]) begin
      a.in_valid = tbl[i].iv;
      a.in_data = tbl[i].d;
      a.ser_ready = tbl[i].sr;
      #1;
      chk($sformatf("vec%0d", i), sa(), tbl[i].e);
      @(negedge clk);
    end
    // backpressure on 0xA5, ser_ready 0,1,0,1...; in_valid high with random data must be ignored
    w = 8'hA5;
    a.in_valid = 1; a.in_data = w; a.ser_ready = 0;
    #1;
    chk("bp_load", sa(), 5'b10000);
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      sr = logic'(j % 2);
      a.ser_ready = sr;
      a.in_valid = (j != 15);
      a.in_data = 8'($urandom);
      #1;
      chk($sformatf("bp%0d", j), sa(), {(j / 2 == 7) && sr, 1'b1, w[j/2], j / 2 == 7, 1'b1});
      @(negedge clk);
    end
    a.in_valid = 0; a.ser_ready = 1;
    #1;
    chk("bp_idle", sa(), 5'b10000);
    // reset after 3 bits of 0xFF, including a handshake attempt while rst is high
    a.in_valid = 1; a.in_data = 8'hFF;
    @(negedge clk);
    a.in_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst", sa(), 5'b01101);
    rst = 1;
    @(negedge clk);
    a.in_valid = 1; a.in_data = 8'h81;
    #1;
    chk("rst_hold", sa(), 5'b00000);
    @(negedge clk);
    rst = 0; a.in_valid = 0;
    #1;
    chk("rst_rel", sa(), 5'b10000);
    w = 8'h81;
    a.in_valid = 1; a.in_data = w;
    @(negedge clk);
    a.in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("post_rst%0d", i), sa(), {i == 7, 1'b1, w[i], i == 7, 1'b1});
      @(negedge clk);
    end
    #1;
    chk("post_rst_idle", sa(), 5'b10000);
    // MSB-first 0x01
    b.in_valid = 1; b.in_data = 8'h01;
    @(negedge clk);
    b.in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("msb%0d", i), sb(), {i == 7, 1'b1, i == 7, i == 7, 1'b1});
      @(negedge clk);
    end
    #1;
    chk("msb_idle", sb(), 5'b10000);
    // WIDTH=1 back-to-back words 1,0,1,1
    ws = 4'b1101;
    c.in_valid = 1; c.in_data = ws[0];
    #1;
    chk("w1_load", sc(), 5'b10000);
    @(negedge clk);
    for (int k = 1; k < 4; k++) begin
      c.in_data = ws[k];
      #1;
      chk($sformatf("w1_%0d", k), sc(), {1'b1, 1'b1, ws[k-1], 1'b1, 1'b1});
      @(negedge clk);
    end
    c.in_valid = 0;
    #1;
    chk("w1_4", sc(), {1'b1, 1'b1, ws[3], 1'b1, 1'b1});
    @(negedge clk);
    #1;
    chk("w1_idle", sc(), 5'b10000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
